// File: rtl/systolic_array_sequencer_pkg.sv
// Shared types for the systolic array sequencer: data word, FSM state encoding, counter width helper.
`default_nettype none

package systolic_array_sequencer_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  typedef logic [DATA_WIDTH-1:0] data_type;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } seq_state_e;

  // Bits needed to index 0..n-1, never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_array_sequencer_skew_line.sv
// skew_line: per-lane data_type delay line of DEPTH registers; DEPTH=0 degenerates to a wire.
`default_nettype none

module skew_line
  import systolic_array_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  data_type d_i,
  output data_type q_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_ni;
      assign q_o = d_i;
    end else begin : g_regs
      data_type stage [DEPTH];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
        end else begin
          stage[0] <= d_i;
          for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
        end
      end

      assign q_o = stage[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/systolic_array_sequencer.sv
// systolic_array_sequencer: job controller that loads a weight tile, skews activations in, deskews results out.
// Optional SYSTOL_SEQ_PERF_EN adds perf_cycles_o / perf_bubbles_o job counters.
`default_nettype none

module systolic_array_sequencer
  import systolic_array_sequencer_pkg::*;
#(
  parameter  int unsigned ACTIVATION_COUNT = 16,
  parameter  int unsigned WEIGHT_COUNT     = 16,
  parameter  int unsigned MAX_COLS         = 256,
  localparam int unsigned NCOL_W           = $clog2(MAX_COLS + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               start_i,
  input  logic     [NCOL_W-1:0]              n_cols_i,
  output logic                               busy_o,
  output logic                               done_o,
  input  logic                               w_valid_i,
  output logic                               w_ready_o,
  input  data_type [WEIGHT_COUNT-1:0]        w_col_i,
  input  logic                               a_valid_i,
  output logic                               a_ready_o,
  input  data_type [ACTIVATION_COUNT-1:0]    a_col_i,
  output logic                               r_valid_o,
  output data_type [WEIGHT_COUNT-1:0]        r_col_o,
  output logic                               arr_weight_update_o,
  output data_type [WEIGHT_COUNT-1:0]        arr_weight_o,
  output data_type [ACTIVATION_COUNT-1:0]    arr_activation_o,
  input  data_type [WEIGHT_COUNT-1:0]        arr_result_i
`ifdef SYSTOL_SEQ_PERF_EN
  ,
  output logic     [31:0]                    perf_cycles_o,
  output logic     [31:0]                    perf_bubbles_o
`endif
);

  localparam int unsigned ARRAY_LATENCY = ACTIVATION_COUNT + 1;
  localparam int unsigned TAG_DEPTH     = ARRAY_LATENCY + WEIGHT_COUNT - 1;
  localparam int unsigned WCNT_W        = idx_width(ACTIVATION_COUNT);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_LOAD_W = LOAD_W;
  localparam logic [2:0] ST_STREAM = STREAM;
  localparam logic [2:0] ST_DRAIN  = DRAIN;
  localparam logic [2:0] ST_DONE   = DONE;

  localparam logic [WCNT_W-1:0] LAST_W_COL = WCNT_W'(ACTIVATION_COUNT - 1);
  localparam logic [NCOL_W-1:0] ONE_COL    = NCOL_W'(1);

  logic [2:0]                      state;
  logic [2:0]                      state_nxt;
  logic [NCOL_W-1:0]               n_cols_q;
  logic [WCNT_W-1:0]               w_cnt;
  logic [NCOL_W-1:0]               a_cnt;
  logic                            w_accept;
  logic                            a_accept;
  logic                            last_w;
  logic                            last_a;
  logic                            drain_empty;
  logic                            start_accept;
  data_type [ACTIVATION_COUNT-1:0] in_col;
  logic                            in_valid;
  logic [TAG_DEPTH-1:0]            tag;
  data_type [WEIGHT_COUNT-1:0]     deskewed;

  assign busy_o    = (state != ST_IDLE);
  assign done_o    = (state == ST_DONE);
  assign w_ready_o = (state == ST_LOAD_W);
  assign a_ready_o = (state == ST_STREAM);

  assign start_accept = (state == ST_IDLE) && start_i;
  assign w_accept     = w_ready_o && w_valid_i;
  assign a_accept     = a_ready_o && a_valid_i;
  assign last_w       = w_accept && (w_cnt == LAST_W_COL);
  assign last_a       = a_accept && ((a_cnt + ONE_COL) == n_cols_q);
  // The input register's valid counts as the head of the tag pipeline.
  assign drain_empty  = (tag == '0) && !in_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_i) state_nxt = ST_LOAD_W;
      ST_LOAD_W: if (last_w) state_nxt = (n_cols_q == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM: if (last_a) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (drain_empty) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      n_cols_q <= '0;
      w_cnt    <= '0;
      a_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (start_accept) begin
        n_cols_q <= n_cols_i;
        w_cnt    <= '0;
        a_cnt    <= '0;
      end else begin
        if (w_accept) w_cnt <= w_cnt + 1'b1;
        if (a_accept) a_cnt <= a_cnt + ONE_COL;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arr_weight_update_o <= 1'b0;
      arr_weight_o        <= '0;
    end else begin
      arr_weight_update_o <= w_accept;
      if (w_accept) arr_weight_o <= w_col_i;
    end
  end

  // Non-accepted cycles (bubbles, drain, idle) feed zero columns into the array.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_col   <= '0;
      in_valid <= 1'b0;
      tag      <= '0;
    end else begin
      in_col   <= a_accept ? a_col_i : '0;
      in_valid <= a_accept;
      tag      <= {tag[TAG_DEPTH-2:0], in_valid};
    end
  end

  generate
    for (genvar i = 0; i < ACTIVATION_COUNT; i++) begin : g_in_skew
      skew_line #(
        .DEPTH (i)
      ) u_skew (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (in_col[i]),
        .q_o    (arr_activation_o[i])
      );
    end

    for (genvar z = 0; z < WEIGHT_COUNT; z++) begin : g_out_deskew
      skew_line #(
        .DEPTH (WEIGHT_COUNT - 1 - z)
      ) u_deskew (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (arr_result_i[z]),
        .q_o    (deskewed[z])
      );
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= 1'b0;
      r_col_o   <= '0;
    end else begin
      r_valid_o <= tag[TAG_DEPTH-1];
      r_col_o   <= tag[TAG_DEPTH-1] ? deskewed : '0;
    end
  end

`ifdef SYSTOL_SEQ_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cycles_o  <= '0;
      perf_bubbles_o <= '0;
    end else if (start_accept) begin
      perf_cycles_o  <= '0;
      perf_bubbles_o <= '0;
    end else begin
      if (state != ST_IDLE) perf_cycles_o <= perf_cycles_o + 32'd1;
      if ((state == ST_STREAM) && !a_valid_i) perf_bubbles_o <= perf_bubbles_o + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_array_sequencer.sv
// Bench: sequencer driving a behavioural 16x16 weight-stationary array; results checked against C = W*A.
`default_nettype none

module tb_systolic_array_sequencer;
  import systolic_array_sequencer_pkg::*;

  localparam int AC   = 16;
  localparam int WC   = 16;
  localparam int AL   = AC + 1;
  localparam int LAT  = AL + WC;
  localparam int HD   = AC + WC - 1;
  localparam int MAXJ = 48;

  logic                clk = 1'b0;
  logic                rst_ni = 1'b0;
  logic                start_i = 1'b0;
  logic [8:0]          n_cols_i = '0;
  logic                busy_o, done_o;
  logic                w_valid_i = 1'b0;
  logic                w_ready_o;
  data_type [WC-1:0]   w_col_i = '0;
  logic                a_valid_i = 1'b0;
  logic                a_ready_o;
  data_type [AC-1:0]   a_col_i = '0;
  logic                r_valid_o;
  data_type [WC-1:0]   r_col_o;
  logic                arr_weight_update_o;
  data_type [WC-1:0]   arr_weight_o;
  data_type [AC-1:0]   arr_activation_o;
  data_type [WC-1:0]   arr_result_i;
`ifdef SYSTOL_SEQ_PERF_EN
  logic [31:0]         perf_cycles_o, perf_bubbles_o;
`endif

  always #5 clk = ~clk;

  systolic_array_sequencer #(
    .ACTIVATION_COUNT (AC),
    .WEIGHT_COUNT     (WC),
    .MAX_COLS         (256)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .start_i             (start_i),
    .n_cols_i            (n_cols_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .w_valid_i           (w_valid_i),
    .w_ready_o           (w_ready_o),
    .w_col_i             (w_col_i),
    .a_valid_i           (a_valid_i),
    .a_ready_o           (a_ready_o),
    .a_col_i             (a_col_i),
    .r_valid_o           (r_valid_o),
    .r_col_o             (r_col_o),
    .arr_weight_update_o (arr_weight_update_o),
    .arr_weight_o        (arr_weight_o),
    .arr_activation_o    (arr_activation_o),
    .arr_result_i        (arr_result_i)
`ifdef SYSTOL_SEQ_PERF_EN
    ,
    .perf_cycles_o       (perf_cycles_o),
    .perf_bubbles_o      (perf_bubbles_o)
`endif
  );

  // Array model: lane z result for a column = sum_i W[z][i]*act_i, appearing AL+z cycles after row 0.
  data_type [WC-1:0] wreg [AC];
  data_type [AC-1:0] hist [HD];
  data_type          m_acc;
  int                m_d;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int d = 0; d < HD; d++) hist[d] <= '0;
      for (int i = 0; i < AC; i++) wreg[i] <= '0;
      arr_result_i <= '0;
    end else begin
      if (arr_weight_update_o) begin
        wreg[0] <= arr_weight_o;
        for (int i = 1; i < AC; i++) wreg[i] <= wreg[i-1];
      end
      hist[0] <= arr_activation_o;
      for (int d = 1; d < HD; d++) hist[d] <= hist[d-1];
      for (int z = 0; z < WC; z++) begin
        m_acc = '0;
        for (int i = 0; i < AC; i++) begin
          m_d   = AL + z - i - 2;
          m_acc = m_acc + data_type'(wreg[i][z] * hist[m_d][i]);
        end
        arr_result_i[z] <= m_acc;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  data_type wm [WC][AC];
  data_type am [AC][MAXJ];

  function automatic logic [255:0] golden(input int j);
    logic [255:0] col;
    data_type     acc;
    col = '0;
    for (int z = 0; z < WC; z++) begin
      acc = '0;
      for (int i = 0; i < AC; i++) acc = acc + data_type'(wm[z][i] * am[i][j]);
      col[z*16 +: 16] = acc;
    end
    return col;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_n, beats, dones, wupds, first_beat_cyc;

  always @(negedge clk) begin
    if (rst_ni) begin
      if (arr_weight_update_o) wupds++;
      if (done_o) dones++;
      if (r_valid_o) begin
        if (beats == 0) first_beat_cyc = cyc;
        if (beats < exp_n) check("result_col", r_col_o, golden(beats));
        beats++;
      end
    end
  end

  task automatic run_job(input int n, input bit bubbles, input bit wgaps,
                         input bit restart, input bit abort, input bit ident);
    int i, j, k, t, bub, s_cyc, acc0, d_cyc;
    for (int z = 0; z < WC; z++)
      for (int r = 0; r < AC; r++)
        wm[z][r] = ident ? data_type'(z == r) : data_type'($urandom_range(0, 15));
    for (int r = 0; r < AC; r++)
      for (int c = 0; c < MAXJ; c++)
        am[r][c] = ident ? data_type'(c * 16 + r + 1) : data_type'($urandom_range(0, 15));
    exp_n = n; beats = 0; dones = 0; wupds = 0; first_beat_cyc = -1;
    acc0 = -1; bub = 0;

    @(negedge clk);
    start_i = 1'b1; n_cols_i = 9'(n); s_cyc = cyc + 1;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1);

    i = AC - 1; k = 0; t = 0;
    while (i >= 0 && t < 200) begin
      if (wgaps && (k % 3 == 1)) w_valid_i = 1'b0;
      else begin
        w_valid_i = 1'b1;
        for (int z = 0; z < WC; z++) w_col_i[z] = wm[z][i];
      end
      if (wgaps) begin
        a_valid_i = 1'b1;
        a_col_i   = {AC{16'hDEAD}};
      end
      if (w_valid_i && w_ready_o) i--;
      k++; t++;
      @(negedge clk);
    end
    w_valid_i = 1'b0; a_valid_i = 1'b0;
    check("weight_cols_left", 32'(i + 1), 0);
    if (n == 0) check("done_after_weights", done_o, 1);

    j = 0; k = 0; t = 0;
    while (j < n && t < 2000) begin
      start_i = restart && (j == 5);
      if (restart) n_cols_i = 9'd3;
      if (bubbles && (k % 3 == 2)) begin
        a_valid_i = 1'b0;
        if (a_ready_o) bub++;
      end else begin
        a_valid_i = 1'b1;
        for (int r = 0; r < AC; r++) a_col_i[r] = am[r][j];
      end
      if (a_valid_i && a_ready_o) begin
        if (j == 0) acc0 = cyc + 1;
        j++;
      end
      k++; t++;
      @(negedge clk);
    end
    a_valid_i = 1'b0; start_i = 1'b0;

    if (abort) begin
      repeat (4) @(negedge clk);
      #2 rst_ni = 1'b0;
      #1;
      check("rst_ctrl", {busy_o, done_o, w_ready_o, a_ready_o, r_valid_o, arr_weight_update_o}, 0);
      check("rst_arr_act", arr_activation_o, 0);
      check("rst_arr_w", arr_weight_o, 0);
      check("rst_r_col", r_col_o, 0);
      @(negedge clk);
      rst_ni = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_no_done", 32'(dones), 0);
      check("abort_no_beats", 32'(beats), 0);
      return;
    end

    t = 0;
    while (!done_o && t < 300) begin
      t++;
      @(negedge clk);
    end
    check("done_seen", done_o, 1);
    d_cyc = cyc;
    @(negedge clk);
    check("busy_dropped", {busy_o, done_o}, 0);
    repeat (2) @(negedge clk);
    check("beat_count", 32'(beats), 32'(n));
    check("done_count", 32'(dones), 1);
    check("weight_updates", 32'(wupds), 16);
    if (n > 0) check("latency", 32'(first_beat_cyc - acc0), 32'(LAT));
`ifdef SYSTOL_SEQ_PERF_EN
    check("perf_bubbles", perf_bubbles_o, 32'(bub));
    check("perf_cycles", perf_cycles_o, 32'(d_cyc - s_cyc + 1));
`else
    if (bub < 0) check("bubble_count", 32'(bub), 0);
    if (d_cyc < s_cyc) check("cycle_order", 32'(d_cyc), 32'(s_cyc));
`endif
  endtask

  initial begin
    exp_n = 0; beats = 0; dones = 0; wupds = 0; first_beat_cyc = -1;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {busy_o, done_o, w_ready_o, a_ready_o, r_valid_o, arr_weight_update_o}, 0);
    check("reset_arr_act", arr_activation_o, 0);
    check("reset_r_col", r_col_o, 0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    run_job(16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_job(16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_job(16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_job(0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_job(40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_job(16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_job(16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
